// File: rtl/ifetch_prefetch_queue_if.sv
// Fetch front-end bundle: redirect input, memory request/response channels and the
// instruction stream toward IF/ID. master = fetch unit, slave = surrounding core/memory.
interface ifetch_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 3
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [CNT_W-1:0]  queue_count;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, queue_count
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, queue_count
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers in-order responses
// in a DEPTH-entry FIFO and flushes/refetches on a branch redirect.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   clr,
  ifetch_prefetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(2 * DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [INF_W-1:0]  inflight;
  logic [INF_W-1:0]  discard;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [INF_W:0]    pending;
  logic              req_valid;
  logic              accept;
  logic              rsp_fire;
  logic              drop;
  logic              push;
  logic              pop;
  logic              head_valid;

  // Responses are in order and every stale one is dropped, so the PC of the next kept
  // response is simply tracked in rsp_pc instead of a PC side-FIFO.
  always_comb begin
    pending    = (INF_W + 1)'(count) + (INF_W + 1)'(inflight - discard);
    req_valid  = !bus.redirect_valid && (pending < (INF_W + 1)'(DEPTH));
    accept     = req_valid && bus.mem_req_ready;
    rsp_fire   = bus.mem_rsp_valid && (inflight != '0);
    drop       = rsp_fire && (discard != '0);
    push       = rsp_fire && !drop && !bus.redirect_valid;
    head_valid = (count != '0);
    pop        = head_valid && bus.inst_ready && !bus.redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= inflight + INF_W'(accept) - INF_W'(rsp_fire);
      if (bus.redirect_valid) begin
        // Everything still outstanding after this cycle's retirement belongs to the old path.
        fetch_pc <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        discard  <= inflight - INF_W'(rsp_fire);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (drop) discard <= discard - INF_W'(1);
        if (push) begin
          data_mem[wr_ptr] <= bus.mem_rsp_data;
          pc_mem[wr_ptr]   <= rsp_pc;
          wr_ptr           <= wr_ptr + PTR_W'(1);
          rsp_pc           <= rsp_pc + ADDR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Head fields read as zero while the queue is empty.
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = head_valid;
  assign bus.inst_data     = head_valid ? data_mem[rd_ptr] : '0;
  assign bus.inst_pc       = head_valid ? pc_mem[rd_ptr] : '0;
  assign bus.queue_count   = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (clr)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule
